shift_reg_pipo: RTL and testbench

- Parallel-in/parallel-out data register: captures the full input word on every rising clock edge and presents it on the output.
- Used as a one-cycle retiming/holding stage on a byte-wide datapath.
- No enable and no shift-direction control; every clock edge loads.
- Optional extra pipeline depth is available by parameter; the default configuration is one stage.

---
 rtl/shift_reg_pkg.sv | 9 +
 rtl/reg_stage_arst_n.sv | 27 ++
 rtl/shift_reg_pipo.sv | 44 ++++
 tb/tb_shift_reg_pipo.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared constants and the default data-word type for the parallel-in/parallel-out register.
package shift_reg_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_STAGES    = 16;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_stage_arst_n.sv
// Single WIDTH-bit register stage, asynchronously forced to RESET_VALUE while rst_n is low.
module reg_stage_arst_n #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  assign data_d = d_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/shift_reg_pipo.sv
// Parallel-in/parallel-out register: every rising edge loads d; q appears STAGES edges later.
module shift_reg_pipo
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("shift_reg_pipo: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
  end

  logic [WIDTH-1:0] stage_q [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    // Stage 0 takes the input word; later stages take their predecessor.
    if (k == 0) begin : g_head
      assign stage_d = d;
    end else begin : g_link
      assign stage_d = stage_q[k-1];
    end

    reg_stage_arst_n #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk   (clk),
      .rst_n (reset_n),
      .d_i   (stage_d),
      .q_o   (stage_q[k])
    );
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: tb/tb_shift_reg_pipo.sv
// Directed bench for shift_reg_pipo: default one-stage instance plus a three-stage instance.
module tb_shift_reg_pipo;
  import shift_reg_pkg::*;

  logic  clk;
  logic  reset_n;
  word_t d;
  word_t q;
  word_t q3;

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];

  shift_reg_pipo dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .q       (q)
  );

  shift_reg_pipo #(.STAGES(3)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .q       (q3)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking task
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_check(input string tag, input logic [7:0] v);
    d = v;
    tick();
    check_eq(tag, q, v);
  endtask

  logic [7:0] v;
  logic [7:0] walk;
  logic [7:0] depth_vals [6];

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    d       = 8'hA5;
    #1;
    check_eq("reset_async", q, 8'h00);

    // reset held for two edges with d = A5
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("reset_hold", q, 8'h00);
      check_eq("reset_hold_s3", q3, 8'h00);
    end

    reset_n = 1'b1;
    tick();
    check_eq("reset_release", q, 8'hA5);

    // single load, nothing visible before the edge
    d = 8'h3C;
    #3;
    check_eq("single_pre", q, 8'hA5);
    tick();
    check_eq("single_post", q, 8'h3C);

    // random sweep through the scoreboard
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom_range(0, 255));
      d = v;
      exp_q.push_back(v);
      #($urandom_range(0, 3));
      tick();
      check_eq("random", q, exp_q.pop_front());
    end

    // no transparency between edges
    load_and_check("transp_base", 8'h00);
    d = 8'hFF;
    #2;
    check_eq("transp_ff", q, 8'h00);
    d = 8'h0F;
    #2;
    check_eq("transp_0f", q, 8'h00);
    tick();
    check_eq("transp_edge", q, 8'h0F);

    // async reset midway between edges
    load_and_check("arst_pre", 8'h5A);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("arst_now", q, 8'h00);
    check_eq("arst_now_s3", q3, 8'h00);
    d = 8'h77;
    tick();
    check_eq("arst_edge_noload", q, 8'h00);
    reset_n = 1'b1;
    tick();
    check_eq("arst_recover", q, 8'h77);

    // bit-exact patterns
    for (int i = 0; i < 8; i++) begin
      walk = 8'h01 << i;
      load_and_check("walk_one", walk);
    end
    load_and_check("all_ones", 8'hFF);
    load_and_check("pat_55", 8'h55);
    load_and_check("pat_aa", 8'hAA);

    // three-stage depth: the last loads were FF, 55, AA
    depth_vals[0] = 8'h11;
    depth_vals[1] = 8'h22;
    depth_vals[2] = 8'h33;
    depth_vals[3] = 8'h44;
    depth_vals[4] = 8'hC3;
    depth_vals[5] = 8'h96;
    exp3_q.push_back(8'h55);
    exp3_q.push_back(8'hAA);
    for (int i = 0; i < 6; i++) begin
      d = depth_vals[i];
      exp3_q.push_back(depth_vals[i]);
      tick();
      check_eq("depth_s1", q, depth_vals[i]);
      check_eq("depth_s3", q3, exp3_q.pop_front());
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
